// File: rtl/gray_ctrl_pkg.sv
// Shared types and helpers for the Gray counter run/pause/step controller.
// State encoding is visible on state_o, so the enum values are fixed.
package gray_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        STEP  = 2'b11
    } state_t;

    localparam int TERM_W = 32;

    // Terminal Gray code for an n-bit counter: MSB-only when counting up, zero when counting down.
    function automatic logic [TERM_W-1:0] gray_term(input logic up, input int n);
        logic [TERM_W-1:0] term;
        term = '0;
        if (up) term[n-1] = 1'b1;
        return term;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser per bit, followed by a previous-value flop that
// turns each synchronised rising edge into a single-cycle pulse.
module sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] meta;
    logic [W-1:0] sync;
    logic [W-1:0] prev;

    // NOTE: non-blocking assignments make the three flops shift together on one edge;
    // blocking ones here would collapse the chain into a single flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;

endmodule

// File: rtl/gray_step_controller.sv
// Run/pause/single-step sequencer issuing enable, direction and clear to one
// N-bit Gray counter, with a prescaler for RUN mode and wrap detection.
module gray_step_controller
    import gray_ctrl_pkg::*;
#(
    parameter int N        = 8,
    parameter int DISTANCE = 1000,
    parameter int DIV_W    = $clog2(DISTANCE + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_btn,
    input  logic         stop_btn,
    input  logic         step_btn,
    input  logic         dir_sw,
    input  logic [N-1:0] gray_in,
    output logic         cnt_en,
    output logic         cnt_up,
    output logic         cnt_clr,
    output logic [1:0]   state_o,
    output logic         wrap_o
);

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DISTANCE - 1);

    state_t           state;
    logic [DIV_W-1:0] presc;
    logic [3:0]       lvl;
    logic [3:0]       rise;
    logic             start_cmd;
    logic             stop_cmd;
    logic             step_cmd;
    logic             dir_lvl;
    logic             unused_sync;
    logic [N-1:0]     term;

    sync_edge #(.W(4)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   ({dir_sw, step_btn, stop_btn, start_btn}),
        .level (lvl),
        .rise  (rise)
    );

    assign start_cmd   = rise[0];
    assign stop_cmd    = rise[1];
    assign step_cmd    = rise[2];
    assign dir_lvl     = lvl[3];
    assign unused_sync = ^{lvl[2:0], rise[3]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            presc   <= '0;
            cnt_clr <= 1'b0;
            cnt_up  <= 1'b0;
        end else begin
            cnt_clr <= 1'b0;
            // Direction is frozen across an enable cycle so the counter never sees it change mid-step.
            if (!cnt_en) cnt_up <= dir_lvl;

            unique case (state)
                IDLE: begin
                    if (stop_cmd) begin
                        state <= IDLE;
                    end else if (start_cmd) begin
                        state <= RUN;
                        presc <= '0;
                    end else if (step_cmd) begin
                        state <= STEP;
                    end
                end
                RUN: begin
                    presc <= (presc == PRESC_LAST) ? '0 : presc + DIV_W'(1);
                    if (stop_cmd) state <= PAUSE;
                end
                PAUSE: begin
                    if (stop_cmd) begin
                        state   <= IDLE;
                        presc   <= '0;
                        cnt_clr <= 1'b1;
                    end else if (start_cmd) begin
                        state <= RUN;
                    end else if (step_cmd) begin
                        state <= STEP;
                    end
                end
                STEP: state <= PAUSE;
                default: state <= IDLE;
            endcase
        end
    end

    // Enable is decoded from registered state only, so it is a clean one-cycle pulse.
    assign cnt_en  = ((state == RUN) && (presc == PRESC_LAST)) || (state == STEP);
    assign term    = N'(gray_term(cnt_up, N));
    assign wrap_o  = cnt_en && (gray_in == term);
    assign state_o = state;

endmodule

// File: tb/tb_gray_step_controller.sv
// Directed bench for gray_step_controller (N=4, DISTANCE=4) with a behavioural
// Gray counter closing the loop on cnt_en/cnt_up/cnt_clr.
module tb_gray_step_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_btn, stop_btn, step_btn, dir_sw;
    logic [3:0] gray;
    logic       cnt_en, cnt_up, cnt_clr, wrap_o;
    logic [1:0] state_o;

    int n_cmp = 0;
    int n_err = 0;
    int up_viol = 0;
    int both_viol = 0;
    logic prev_en = 1'b0;
    logic prev_up = 1'b0;

    gray_step_controller #(.N(4), .DISTANCE(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_btn (start_btn),
        .stop_btn  (stop_btn),
        .step_btn  (step_btn),
        .dir_sw    (dir_sw),
        .gray_in   (gray),
        .cnt_en    (cnt_en),
        .cnt_up    (cnt_up),
        .cnt_clr   (cnt_clr),
        .state_o   (state_o),
        .wrap_o    (wrap_o)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Behavioural Gray counter driven by the controller.
    always @(posedge clk or negedge reset) begin
        if (!reset)       gray <= 4'b0000;
        else if (cnt_clr) gray <= 4'b0000;
        else if (cnt_en)  gray <= cnt_up ? b2g(g2b(gray) + 4'd1) : b2g(g2b(gray) - 4'd1);
    end

    // Direction must not change at the edge that closes an enable cycle; enable and clear never overlap.
    always @(negedge clk) begin
        if (reset) begin
            if (prev_en && (cnt_up !== prev_up)) up_viol <= up_viol + 1;
            if (cnt_en && cnt_clr) both_viol <= both_viol + 1;
        end
        prev_en <= cnt_en;
        prev_up <= cnt_up;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise the selected buttons, check state just before and just after the edge k+2.
    task automatic press(input logic b_start, input logic b_stop, input logic b_step,
                         input logic [1:0] pre_st, input logic [1:0] post_st, input string tag);
        if (b_start) start_btn = 1'b1;
        if (b_stop)  stop_btn  = 1'b1;
        if (b_step)  step_btn  = 1'b1;
        tick();
        tick();
        check({tag, "_pre"}, state_o, pre_st);
        tick();
        check({tag, "_post"}, state_o, post_st);
        if (b_start) start_btn = 1'b0;
        if (b_stop)  stop_btn  = 1'b0;
        if (b_step)  step_btn  = 1'b0;
    endtask

    // Whole prescaler periods in RUN starting from prescaler 0: enable on the third cycle.
    task automatic run_periods(input int count, input int wrap_at, input string tag);
        for (int p = 0; p < count; p++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                check({tag, "_en"}, cnt_en, (i == 2));
                if (i == 2) check({tag, "_wrap"}, wrap_o, (p == wrap_at));
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        start_btn = 1'b0; stop_btn = 1'b0; step_btn = 1'b0; dir_sw = 1'b1;

        // Reset held with buttons toggling
        for (int i = 0; i < 4; i++) begin
            tick();
            start_btn = ~start_btn; stop_btn = (i % 2 == 0); step_btn = ~step_btn;
            check("rst_state", state_o, 2'b00);
            check("rst_en", cnt_en, 1'b0);
            check("rst_clr", cnt_clr, 1'b0);
            check("rst_wrap", wrap_o, 1'b0);
        end
        start_btn = 1'b0; stop_btn = 1'b0; step_btn = 1'b0;
        #14 reset = 1'b1;
        repeat (4) tick();
        check("idle_state", state_o, 2'b00);
        check("idle_up", cnt_up, 1'b1);
        check("idle_en", cnt_en, 1'b0);

        // IDLE commands: STOP stays idle, STEP steps once, STOP from PAUSE clears
        press(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, "idle_stop");
        check("idle_stop_clr", cnt_clr, 1'b0);
        press(1'b0, 1'b0, 1'b1, 2'b00, 2'b11, "idle_step");
        check("idle_step_en", cnt_en, 1'b1);
        check("idle_step_wrap", wrap_o, 1'b0);
        tick();
        check("idle_step_back", state_o, 2'b10);
        check("idle_step_gray", gray, 4'b0001);
        press(1'b0, 1'b1, 1'b0, 2'b10, 2'b00, "pause_clr");
        check("pause_clr_pulse", cnt_clr, 1'b1);
        check("pause_clr_en", cnt_en, 1'b0);
        tick();
        check("pause_clr_drop", cnt_clr, 1'b0);
        check("pause_clr_gray", gray, 4'b0000);

        // RUN: 8 enables, stop issued so RUN keeps prescaler cycles 0 and 1
        press(1'b1, 1'b0, 1'b0, 2'b00, 2'b01, "run_start");
        check("run_first_en", cnt_en, 1'b0);
        run_periods(7, -1, "run");
        tick(); tick(); tick();
        check("run_8th_en", cnt_en, 1'b1);
        press(1'b0, 1'b1, 1'b0, 2'b01, 2'b10, "run_stop");
        check("run_gray8", gray, 4'b1100);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_no_en", cnt_en, 1'b0);
            check("pause_hold", state_o, 2'b10);
        end

        // Resume: prescaler continues from 2, so enable on the second RUN cycle
        press(1'b1, 1'b0, 1'b0, 2'b10, 2'b01, "resume");
        check("resume_en0", cnt_en, 1'b0);
        tick();
        check("resume_en1", cnt_en, 1'b1);
        press(1'b0, 1'b1, 1'b0, 2'b01, 2'b10, "resume_stop");
        check("resume_gray", gray, 4'b1101);

        // STEP from PAUSE with a START arriving during the STEP cycle
        step_btn = 1'b1;
        tick();
        start_btn = 1'b1;
        tick();
        check("step_pre", state_o, 2'b10);
        tick();
        check("step_state", state_o, 2'b11);
        check("step_en", cnt_en, 1'b1);
        step_btn = 1'b0;
        tick();
        check("step_back", state_o, 2'b10);
        check("step_en_off", cnt_en, 1'b0);
        start_btn = 1'b0;
        tick(); tick();
        check("step_start_dropped", state_o, 2'b10);
        check("step_gray", gray, 4'b1111);
        press(1'b0, 1'b1, 1'b0, 2'b10, 2'b00, "step_clr");
        check("step_clr_pulse", cnt_clr, 1'b1);
        tick();
        check("step_clr_gray", gray, 4'b0000);

        // Wrap up at 1000, then down through 0000 twice
        press(1'b1, 1'b0, 1'b0, 2'b00, 2'b01, "wrap_start");
        run_periods(16, 15, "wrap_up");
        check("wrap_up_gray", gray, 4'b0000);
        dir_sw = 1'b0;
        tick(); tick(); tick();
        check("dn_first_en", cnt_en, 1'b1);
        check("dn_first_up", cnt_up, 1'b0);
        check("dn_first_wrap", wrap_o, 1'b1);
        tick();
        check("dn_first_gray", gray, 4'b1000);
        run_periods(16, 15, "wrap_dn");
        check("wrap_dn_gray", gray, 4'b1000);

        // Direction flip landing on an enable cycle is held one cycle
        tick();
        dir_sw = 1'b1;
        tick(); tick();
        check("flip_en", cnt_en, 1'b1);
        check("flip_up_held", cnt_up, 1'b0);
        check("flip_wrap", wrap_o, 1'b0);
        tick();
        check("flip_up_still", cnt_up, 1'b0);
        check("flip_gray", gray, 4'b1001);
        tick();
        check("flip_up_new", cnt_up, 1'b1);

        // Simultaneous commands: START+STOP from RUN, all three from PAUSE
        press(1'b1, 1'b1, 1'b0, 2'b01, 2'b10, "sim_run");
        check("sim_run_gray", gray, 4'b1000);
        tick(); tick();
        press(1'b1, 1'b1, 1'b1, 2'b10, 2'b00, "sim_pause");
        check("sim_pause_clr", cnt_clr, 1'b1);
        tick();
        check("sim_pause_gray", gray, 4'b0000);

        // Reset asserted mid-RUN on an enable cycle
        press(1'b1, 1'b0, 1'b0, 2'b00, 2'b01, "mid_start");
        tick(); tick(); tick();
        check("mid_en", cnt_en, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_state", state_o, 2'b00);
        check("mid_rst_en", cnt_en, 1'b0);
        check("mid_rst_clr", cnt_clr, 1'b0);
        check("mid_rst_wrap", wrap_o, 1'b0);
        check("mid_rst_up", cnt_up, 1'b0);
        #5 reset = 1'b1;
        tick();
        check("mid_after_state", state_o, 2'b00);

        check("up_hold_viol", up_viol, 0);
        check("en_clr_overlap", both_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
